// File: rtl/relm_fp_pkg.sv
// relm_fp_pkg: shared definitions for the ReLM floating-point pack back end.
//   state_t      - pack FSM states
//   EXP_MAX/QNAN - IEEE-754 single special encodings
//   B_*          - field positions inside the sign/exponent/flag word
//   HIDDEN_BIT   - mantissa bit carrying weight 1.0
package relm_fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  localparam int unsigned B_SIGN   = 31;
  localparam int unsigned B_EXP_HI = 30;
  localparam int unsigned B_EXP_LO = 23;
  localparam int unsigned B_INF    = 22;
  localparam int unsigned B_ZERO   = 21;

  localparam int unsigned HIDDEN_BIT = 30;

  function automatic logic [31:0] signed_zero(input logic sign);
    return {sign, 31'd0};
  endfunction

  function automatic logic [31:0] signed_inf(input logic sign);
    return {sign, EXP_MAX, 23'd0};
  endfunction

endpackage

// File: rtl/relm_fp_round.sv
// relm_fp_round: combinational round-to-nearest-even packer.
//   sign - result sign
//   m    - normalised mantissa (1.0 at bit 30, carry at bit 31)
//   e    - 10-bit signed biased exponent matching m
//   q    - packed IEEE-754 single
//   ovf  - result saturated to infinity
//   unf  - result flushed to signed zero
module relm_fp_round
  import relm_fp_pkg::*;
(
  input  logic              sign,
  input  logic [31:0]       m,
  input  logic signed [9:0] e,
  output logic [31:0]       q,
  output logic              ovf,
  output logic              unf
);

  logic [22:0]       frac;
  logic              guard;
  logic              sticky;
  logic [23:0]       frac_r;
  logic signed [9:0] e_r;

  always_comb begin
    frac   = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    e_r    = e;
    if (m[31]) begin
      frac   = m[30:8];
      guard  = m[7];
      sticky = |m[6:0];
      e_r    = e + 10'sd1;
    end else begin
      frac   = m[29:7];
      guard  = m[6];
      sticky = |m[5:0];
    end

    // Bit 23 of frac_r is the fraction carry-out; the low 23 bits are then zero.
    frac_r = {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
    if (frac_r[23]) begin
      e_r = e_r + 10'sd1;
    end

    q   = {sign, e_r[7:0], frac_r[22:0]};
    ovf = 1'b0;
    unf = 1'b0;
    if (e_r >= 10'sd255) begin
      q   = signed_inf(sign);
      ovf = 1'b1;
    end else if (e_r <= 10'sd0) begin
      q   = signed_zero(sign);
      unf = 1'b1;
    end
  end

endmodule

// File: rtl/relm_fp_pack.sv
// relm_fp_pack: normalise / round / pack back end of the ReLM FP path.
//   clk, rst  - clock, synchronous active-high reset
//   in_valid  - a_in/b_in hold an intermediate; in_ready high only in IDLE
//   a_in      - mantissa word (1.0 at bit 30, carry at bit 31)
//   b_in      - {sign, exp[7:0], inf, zero, don't-care}
//   out_valid - q_out/ovf_out/unf_out valid; held until out_ready
//   q_out     - packed IEEE-754 single
//   ovf_out   - overflowed to infinity
//   unf_out   - flushed to zero by underflow
module relm_fp_pack
  import relm_fp_pkg::*;
#(
  parameter int WD        = 32,
  parameter int BIG_SHIFT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WD-1:0] a_in,
  input  logic [WD-1:0] b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] q_out,
  output logic          ovf_out,
  output logic          unf_out
);

  localparam logic signed [9:0] BIG_E = 10'(BIG_SHIFT);

  state_t            state, state_n;
  logic              sign_r, sign_n;
  logic [31:0]       m_r, m_n;
  logic signed [9:0] e_r, e_n;
  logic [31:0]       q_r, q_n;
  logic              ovf_r, ovf_n;
  logic              unf_r, unf_n;

  logic [31:0]       rnd_q;
  logic              rnd_ovf;
  logic              rnd_unf;

  logic              b_unused;
  assign b_unused = ^b_in[20:0];

  relm_fp_round u_round (
    .sign (sign_r),
    .m    (m_r),
    .e    (e_r),
    .q    (rnd_q),
    .ovf  (rnd_ovf),
    .unf  (rnd_unf)
  );

  always_comb begin
    state_n = state;
    sign_n  = sign_r;
    m_n     = m_r;
    e_n     = e_r;
    q_n     = q_r;
    ovf_n   = ovf_r;
    unf_n   = unf_r;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_n  = b_in[B_SIGN];
          m_n     = a_in;
          e_n     = {2'b00, b_in[B_EXP_HI:B_EXP_LO]};
          ovf_n   = 1'b0;
          unf_n   = 1'b0;
          state_n = DONE;
          if (b_in[B_INF] && b_in[B_ZERO]) begin
            q_n = QNAN;
          end else if (b_in[B_INF]) begin
            q_n = signed_inf(b_in[B_SIGN]);
          end else if (b_in[B_ZERO]) begin
            q_n = signed_zero(b_in[B_SIGN]);
          end else if (a_in == '0) begin
            q_n = '0;
          end else begin
            state_n = NORM;
          end
        end
      end
      NORM: begin
        if (m_r[31:30] != 2'b00) begin
          state_n = ROUND;
        end else if ((m_r[HIDDEN_BIT -: 8] == 8'd0) && (e_r > BIG_E)) begin
          m_n = m_r << BIG_SHIFT;
          e_n = e_r - BIG_E;
        end else if (e_r > 10'sd1) begin
          m_n = m_r << 1;
          e_n = e_r - 10'sd1;
        end else begin
          q_n     = signed_zero(sign_r);
          unf_n   = 1'b1;
          state_n = DONE;
        end
      end
      ROUND: begin
        q_n     = rnd_q;
        ovf_n   = rnd_ovf;
        unf_n   = rnd_unf;
        state_n = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sign_r <= 1'b0;
      m_r    <= '0;
      e_r    <= '0;
      q_r    <= '0;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
    end else begin
      state  <= state_n;
      sign_r <= sign_n;
      m_r    <= m_n;
      e_r    <= e_n;
      q_r    <= q_n;
      ovf_r  <= ovf_n;
      unf_r  <= unf_n;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign q_out     = q_r;
  assign ovf_out   = ovf_r;
  assign unf_out   = unf_r;

endmodule

// File: tb/tb_relm_fp_pack.sv
module tb_relm_fp_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] q_out;
  logic        ovf_out;
  logic        unf_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run = 1'b0;
  bit hold = 1'b0;

  typedef struct {
    logic [31:0] q;
    logic        ov;
    logic        un;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  bit   seen = 1'b0;

  relm_fp_pack #(.WD(32), .BIG_SHIFT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_out     (q_out),
    .ovf_out   (ovf_out),
    .unf_out   (unf_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: locate the leading one, walk the normalisation rules on
  // (position, exponent), then round the value numerically.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic ov,
                                output logic un, output int lat);
    logic s;
    int ex, p, k, tot, sh;
    longint mant, keep, rem, half;
    s = b[31]; ex = int'(b[30:23]);
    q = '0; ov = 1'b0; un = 1'b0; lat = 1;
    if (b[22] && b[21])      q = 32'h7FC00000;
    else if (b[22])          q = {s, 8'hFF, 23'd0};
    else if (b[21])          q = {s, 31'd0};
    else if (a == 32'd0)     q = 32'd0;
    else begin
      p = 31;
      while (a[p] == 1'b0) p--;
      k = 0; tot = 0;
      while (p < 30) begin
        if (p < 23 && ex > 8) begin p += 8; ex -= 8; tot += 8; end
        else if (ex > 1)      begin p += 1; ex -= 1; tot += 1; end
        else break;
        k++;
      end
      if (p < 30) begin
        q = {s, 31'd0}; un = 1'b1; lat = 2 + k;
      end else begin
        lat  = 3 + k;
        mant = longint'(a) << tot;
        sh   = (p == 31) ? 8 : 7;
        if (p == 31) ex++;
        keep = mant >> sh;
        rem  = mant & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep++;
        if (keep >= (64'd1 << 24)) begin keep = keep >> 1; ex++; end
        if (ex >= 255)     begin q = {s, 8'hFF, 23'd0}; ov = 1'b1; end
        else if (ex <= 0)  begin q = {s, 31'd0}; un = 1'b1; end
        else               q = {s, 8'(ex), 23'(keep)};
      end
    end
  endfunction

  // Compare process: scoreboard of accepted inputs against DUT outputs.
  always @(negedge clk) begin
    if (run) begin
      exp_t x;
      chk("in_ready", {31'd0, in_ready}, {31'd0, sb.size() == 0});
      if (sb.size() == 0) begin
        chk("out_valid_idle", {31'd0, out_valid}, 32'd0);
      end else if (out_valid) begin
        if (!seen) begin
          chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          seen = 1'b1;
        end
        chk("q_out", q_out, sb[0].q);
        chk("ovf_out", {31'd0, ovf_out}, {31'd0, sb[0].ov});
        chk("unf_out", {31'd0, unf_out}, {31'd0, sb[0].un});
        if (out_ready && !rst) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
      if (rst) begin
        sb.delete();
        seen = 1'b0;
      end else if (in_valid && in_ready) begin
        model(a_in, b_in, x.q, x.ov, x.un, x.lat);
        x.acc = cyc;
        sb.push_back(x);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    a_in = a; b_in = b; in_valid = 1'b1;
    do begin
      @(negedge clk); n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=busy required=ready");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = $urandom; b_in = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin @(posedge clk); #1; n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        ov;
    logic        un;
    int          lat;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [31:0] mq;
    logic mo, mu;
    int ml;
    vt[0]  = '{32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 3};
    vt[1]  = '{32'hC0000000, 32'hBF800000, 32'hC0400000, 1'b0, 1'b0, 3};
    vt[2]  = '{32'h00000080, 32'h3F800000, 32'h34000000, 1'b0, 1'b0, 12};
    vt[3]  = '{32'h40000040, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 3};
    vt[4]  = '{32'h400000C0, 32'h3F800000, 32'h3F800002, 1'b0, 1'b0, 3};
    vt[5]  = '{32'h7FFFFFC0, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 3};
    vt[6]  = '{32'h80000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 3};
    vt[7]  = '{32'h12345678, 32'h80400000, 32'hFF800000, 1'b0, 1'b0, 1};
    vt[8]  = '{32'h12345678, 32'h00600000, 32'h7FC00000, 1'b0, 1'b0, 1};
    vt[9]  = '{32'h00000100, 32'h01000000, 32'h00000000, 1'b0, 1'b1, 3};
    vt[10] = '{32'h40000000, 32'h80200000, 32'h80000000, 1'b0, 1'b0, 1};
    vt[11] = '{32'h00000000, 32'hBF800000, 32'h00000000, 1'b0, 1'b0, 1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0; run = 1'b1;
    @(negedge clk);
    chk("reset_q", q_out, 32'd0);
    chk("reset_ovf", {31'd0, ovf_out}, 32'd0);
    chk("reset_unf", {31'd0, unf_out}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Hand-computed expectations pin the reference model, then the DUT runs them.
    foreach (vt[i]) begin
      model(vt[i].a, vt[i].b, mq, mo, mu, ml);
      chk("pin_q", mq, vt[i].q);
      chk("pin_ovf", {31'd0, mo}, {31'd0, vt[i].ov});
      chk("pin_unf", {31'd0, mu}, {31'd0, vt[i].un});
      chk("pin_lat", 32'(ml), 32'(vt[i].lat));
      send(vt[i].a, vt[i].b);
      drain();
    end

    // Consumer stall: result held, stray requests ignored.
    hold = 1'b1;
    send(32'h40000000, 32'h3F800000);
    in_valid = 1'b1; a_in = 32'h40000000; b_in = 32'h40000000;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("hold_q", q_out, 32'h3F800000);
    chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    hold = 1'b0;
    drain();

    // Reset during NORM.
    send(32'h00000080, 32'h3F800000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, b;
      int r;
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) a = 32'd0;
      if ($urandom_range(0, 7) == 0) a = a | 32'h80000000;
      b = $urandom;
      if ($urandom_range(0, 1) == 0) b[30:23] = 8'(8'h70 + $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) b[30:23] = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) b[30:23] = 8'($urandom_range(250, 255));
      r = $urandom_range(0, 15);
      b[22] = (r == 0 || r == 2);
      b[21] = (r == 1 || r == 2);
      send(a, b);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
